// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  localparam int unsigned BYTE_W = 8;

  // Number of bits the next byte contributes, given how many chain bits remain.
  function automatic logic [3:0] chunk_bits(input int unsigned remaining);
    return (remaining >= BYTE_W) ? 4'(BYTE_W) : 4'(remaining);
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Collects bits leaving the chain tail into readback bytes, first bit in the MSB.
module ccff_rb_packer
  import ccff_loader_pkg::*;
(
  input  logic       prog_clk,
  input  logic       pReset,
  input  logic       shift,
  input  logic       tail,
  input  logic       last,
  output logic [7:0] rb_data,
  output logic       rb_valid
);

  logic [3:0] fill_q;
  logic [7:0] rb_sreg_q;
  logic [7:0] rb_data_q;
  logic       rb_valid_q;

  logic [7:0] captured;
  logic [3:0] fill_inc;
  logic [7:0] flush_byte;

  always_comb begin
    captured   = {rb_sreg_q[6:0], tail};
    fill_inc   = fill_q + 4'd1;
    // A short final group is left-justified; a full byte shifts by zero.
    flush_byte = captured << (4'(BYTE_W) - fill_inc);
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      fill_q     <= '0;
      rb_sreg_q  <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (shift) begin
        rb_sreg_q <= captured;
        if (fill_inc == 4'(BYTE_W) || last) begin
          rb_data_q  <= flush_byte;
          rb_valid_q <= 1'b1;
          fill_q     <= '0;
        end else begin
          fill_q <= fill_inc;
        end
      end
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream bytes onto the ccff chain head and reads back the tail.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 6,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic             prog_clk,
  input  logic             pReset,
  input  logic             start,
  input  logic [7:0]       cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             ccff_head,
  input  logic             ccff_tail,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rb_data,
  output logic             rb_valid,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

  state_e           state_q;
  logic [7:0]       sreg_q;
  logic [3:0]       nbits_q;
  logic [CNT_W-1:0] bit_count_q;
  logic             cfg_ready_q;
  logic             shift_en_q;
  logic             head_q;
  logic             busy_q;
  logic             done_q;

  logic [3:0] load_bits;
  logic       last_bit;
  logic       pass_end;

  always_comb begin
    load_bits = chunk_bits(CHAIN_LEN - 32'(bit_count_q));
    last_bit  = (nbits_q == 4'd1);
    pass_end  = shift_en_q && last_bit && (bit_count_q == LAST_IDX);
  end

  // Outputs are registered alongside the state so the chain sees clean enables.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      nbits_q     <= '0;
      bit_count_q <= '0;
      cfg_ready_q <= 1'b0;
      shift_en_q  <= 1'b0;
      head_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StLoad;
            bit_count_q <= '0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        StLoad: begin
          if (cfg_valid) begin
            state_q     <= StShift;
            sreg_q      <= cfg_data;
            nbits_q     <= load_bits;
            head_q      <= cfg_data[7];
            shift_en_q  <= 1'b1;
            cfg_ready_q <= 1'b0;
          end
        end
        StShift: begin
          sreg_q      <= {sreg_q[6:0], 1'b0};
          bit_count_q <= bit_count_q + 1'b1;
          nbits_q     <= nbits_q - 4'd1;
          if (last_bit) begin
            shift_en_q <= 1'b0;
            head_q     <= 1'b0;
            if (bit_count_q == LAST_IDX) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q     <= StLoad;
              cfg_ready_q <= 1'b1;
            end
          end else begin
            head_q <= sreg_q[6];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  ccff_rb_packer u_rb_packer (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .shift    (shift_en_q),
    .tail     (ccff_tail),
    .last     (pass_end),
    .rb_data  (rb_data),
    .rb_valid (rb_valid)
  );

  assign cfg_ready = cfg_ready_q;
  assign ccff_head = head_q;
  assign shift_en  = shift_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_count = bit_count_q;

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Drives the configuration-chain end that all connection/switch-block memories hang off: accepts bitstream bytes over a valid/ready interface and serializes them onto ccff_head with a shift enable for the chain.
- Simultaneously captures the bits emerging at ccff_tail and returns them as readback bytes, enabling bitstream verification by a second load pass.
- Sits between the host/SPI bridge and the first chain segment, clocked by prog_clk.

Parameters:
- CHAIN_LEN, 6, total number of ccff bits in the chain (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter (derived; do not override).

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- pReset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load pass; honoured only in IDLE or DONE.
- cfg_data  input  8  bitstream byte, MSB shifted first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader accepts byte this cycle.
- ccff_head  output  1  serial bit into chain.
- ccff_tail  input  1  serial bit out of chain end.
- shift_en  output  1  chain clock enable; the chain shifts on every prog_clk edge where shift_en=1.
- busy  output  1  high in LOAD or SHIFT.
- done  output  1  high in DONE.
- rb_data  output  8  readback byte, first-emerged bit in MSB.
- rb_valid  output  1  one-cycle strobe qualifying rb_data; no backpressure.
- bit_count  output  CNT_W  bits shifted in the current pass.

Behaviour:
- Reset (pReset=0, async) sets state=IDLE. All outputs are 0: cfg_ready, ccff_head, shift_en, busy, done, rb_valid, rb_data, bit_count. The shift register and readback register are also cleared.
- IDLE:
  - start=1 -> LOAD; bit_count cleared.
- LOAD:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready: latch cfg_data into sreg; nbits = min(8, CHAIN_LEN-bit_count); -> SHIFT next cycle.
  - cfg_valid low simply waits; there is no timeout.
- SHIFT:
  - cfg_ready=0, shift_en=1, ccff_head=sreg[7].
  - At each edge: sreg<<=1; rb_sreg <= {rb_sreg[6:0], ccff_tail}; bit_count++; nbits--.
  - ccff_tail is therefore sampled on the same edge the chain shifts, capturing the bit leaving the chain.
  - When nbits reaches 0: if bit_count==CHAIN_LEN -> DONE, otherwise -> LOAD.
  - There is no idle bubble other than the LOAD acceptance cycle, so throughput is 8 bits per 9 cycles.
- Readback:
  - rb_valid pulses the cycle after 8 readback bits accumulate.
  - It also pulses after the final bit of the pass when the partial count is nonzero; the partial byte is left-justified and zero-padded.
  - Exactly ceil(CHAIN_LEN/8) rb_valid pulses occur per pass.
- Final byte: unused LSBs (8-nbits) are discarded and never shifted.
- DONE:
  - done=1, shift_en=0, ccff_head=0.
  - start=1 -> LOAD with bit_count cleared.
- start while busy is ignored with no effect.
- shift_en and ccff_head are register-driven (glitch-free); shift_en=0 outside SHIFT.
- Reset asserted mid-SHIFT aborts immediately; the partially loaded chain contents are the host's problem, and a new start is required.
- bit_count never exceeds CHAIN_LEN.

Decomposition:
- Shared package ccff_loader_pkg:
  - state enum {IDLE, LOAD, SHIFT, DONE};
  - constant BYTE_W=8.
- One natural sub-module: ccff_rb_packer. It holds the readback shift register, the 0..8 fill counter, and the flush-on-last-bit logic, and produces rb_data/rb_valid.
- The FSM, byte serializer and bit counter stay in the top.

Test Plan:
- CHAIN_LEN=6, chain modelled as a 6-bit shift register, start then byte 0xB4:
  - expect exactly 6 shift_en cycles with ccff_head sequence 1,0,1,1,0,1;
  - chain model = 6'b101101; done=1; bit_count=6; one rb_valid with rb_data=0x00.
- Following the above, start then byte 0x00:
  - expect rb_data=0xB4 (101101 left-justified);
  - chain model = 0.
- CHAIN_LEN=20, bytes 0xA5,0x3C,0xF0:
  - expect cfg_ready accepted 3 times;
  - 20 shift cycles total, the last byte contributing only 1111;
  - 3 rb_valid pulses; done asserted after the 20th shift.
- Backpressure: cfg_valid held low 5 cycles between bytes:
  - expect shift_en=0 and cfg_ready=1 throughout the gap;
  - no bit lost, and chain contents are identical to the no-gap run.
- pReset asserted after 3 of 6 shifts:
  - expect all outputs 0 within the same cycle and state IDLE;
  - a subsequent start+byte performs a full 6-bit pass.
- start pulsed during SHIFT:
  - expect it ignored, bit_count continuing monotonically, and a single done.
